// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 2-flop input synchronizer, configurable parity and framing checks.
// Samples at bit centres using a single bit timer; holds off after a framing error until the line returns high.
module uart_rx #(
    parameter int BAUD_RATE = 115200,
    parameter int CLK_FREQ  = 50000000,
    parameter int PARITY    = 0,
    parameter int DATA_LEN  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                r_x,
    output logic [DATA_LEN-1:0] DATA,
    output logic                valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy,
    output logic [1:0]          LED
);
    localparam int BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int TW = $clog2(BIT_CYCLES) + 1;
    localparam int CW = $clog2(DATA_LEN) + 1;
    localparam logic [TW-1:0] BIT_END  = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] HALF_END = TW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_LEN-1:0] shift_q, shift_d, data_q, data_d;
    logic                valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                par_q, par_d, armed_q, armed_d;
    logic                rx_s, bit_end, exp_par;

    assign rx_s    = sync_q[1];
    assign bit_end = timer_q == BIT_END;
    assign exp_par = (PARITY == 0) ? ^shift_q : (PARITY == 1) ? ~^shift_q : (PARITY == 2);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        par_d   = par_q;
        armed_d = armed_q | rx_s;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rx_s && armed_q) state_d = S_START;
            end
            S_START: if (timer_q == HALF_END) begin
                timer_d = '0;
                state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (bit_end) begin
                timer_d = '0;
                shift_d = {rx_s, shift_q[DATA_LEN-1:1]};
                cnt_d   = (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) state_d = S_PAR;
            end
            S_PAR: if (bit_end) begin
                timer_d = '0;
                par_d   = rx_s;
                state_d = S_STOP;
            end
            S_STOP: if (bit_end) begin
                timer_d = '0;
                state_d = S_IDLE;
                data_d  = shift_q;
                perr_d  = par_q != exp_par;
                ferr_d  = !rx_s;
                valid_d = 1'b1;
                // a low stop bit disarms start detection until the line is seen high again
                armed_d = rx_s;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            par_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], r_x};
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            par_q   <= par_d;
            armed_q <= armed_d;
        end
    end

    assign DATA       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = state_q != S_IDLE;
    assign LED        = {~busy, busy};
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives four receivers (PARITY 0..3) with per-line parity bits and checks
// data, flags, pulse counts and latency against a frame-level reference model.
module tb_uart_rx;
    localparam int BIT  = 16;
    localparam int HALF = 8;
    // 2 sync + 1 start detect + half bit + 10 full bits to the stop-bit centre
    localparam int LAT  = 2 + 1 + HALF + 10 * BIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] r_x = 4'hF;
    logic [7:0] data [4];
    logic [1:0] led [4];
    logic [3:0] valid, perr, ferr, busy;

    int n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0;
    int vcnt [4] = '{0, 0, 0, 0};
    int vcyc [4] = '{0, 0, 0, 0};
    int exp_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] exp_data [4];
    logic exp_perr [4], exp_ferr [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        for (int m = 0; m < 4; m++)
            if (valid[m] === 1'b1) begin
                vcnt[m] <= vcnt[m] + 1;
                vcyc[m] <= cyc;
            end

    for (genvar g = 0; g < 4; g++) begin : u
        uart_rx #(.BAUD_RATE(100000), .CLK_FREQ(1600000), .PARITY(g), .DATA_LEN(8)) dut (
            .clk(clk), .rst_n(rst_n), .r_x(r_x[g]), .DATA(data[g]), .valid(valid[g]),
            .parity_err(perr[g]), .frame_err(ferr[g]), .busy(busy[g]), .LED(led[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input int m, input logic [7:0] d);
        int ones = 0;
        logic odd;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        odd = (ones % 2) == 1;
        return (m == 0) ? odd : (m == 1) ? !odd : (m == 2);
    endfunction

    // caller keeps time at posedge+1; nbits < 11 sends a truncated frame with no model update
    task automatic send(input logic [7:0] d, input logic [3:0] flip, input logic stop, input int nbits);
        logic [10:0] bits [4];
        for (int m = 0; m < 4; m++) bits[m] = {stop, good_par(m, d) ^ flip[m], d, 1'b0};
        t0 = cyc;
        for (int b = 0; b < nbits; b++) begin
            for (int m = 0; m < 4; m++) r_x[m] = bits[m][b];
            repeat (BIT) @(posedge clk);
            #1;
        end
        if (nbits == 11)
            for (int m = 0; m < 4; m++) begin
                exp_data[m] = d;
                exp_perr[m] = flip[m];
                exp_ferr[m] = !stop;
                exp_cnt[m]++;
            end
    endtask

    task automatic check_frame(input string tag);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s data[%0d]", tag, m), 32'(data[m]), 32'(exp_data[m]));
            chk($sformatf("%s perr[%0d]", tag, m), 32'(perr[m]), 32'(exp_perr[m]));
            chk($sformatf("%s ferr[%0d]", tag, m), 32'(ferr[m]), 32'(exp_ferr[m]));
            chk($sformatf("%s pulses[%0d]", tag, m), vcnt[m], exp_cnt[m]);
            chk($sformatf("%s latency[%0d]", tag, m), vcyc[m] - t0, LAT);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s busy[%0d]", tag, m), 32'(busy[m]), 0);
            chk($sformatf("%s led[%0d]", tag, m), 32'(led[m]), 32'h2);
            chk($sformatf("%s pulses[%0d]", tag, m), vcnt[m], exp_cnt[m]);
            chk($sformatf("%s data[%0d]", tag, m), 32'(data[m]), 32'(exp_data[m]));
            chk($sformatf("%s ferr[%0d]", tag, m), 32'(ferr[m]), 32'(exp_ferr[m]));
        end
    endtask

    task automatic check_reset(input string tag);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s data[%0d]", tag, m), 32'(data[m]), 0);
            chk($sformatf("%s valid[%0d]", tag, m), 32'(valid[m]), 0);
            chk($sformatf("%s perr[%0d]", tag, m), 32'(perr[m]), 0);
            chk($sformatf("%s ferr[%0d]", tag, m), 32'(ferr[m]), 0);
            chk($sformatf("%s busy[%0d]", tag, m), 32'(busy[m]), 0);
            chk($sformatf("%s led[%0d]", tag, m), 32'(led[m]), 32'h2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [3:0] flip;
        logic       stop;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        send(8'hA5, 4'h0, 1'b1, 11);
        check_frame("a5");
        repeat (3) @(posedge clk);
        #1;

        send(8'h3C, 4'hF, 1'b1, 11);
        check_frame("3c_badpar");
        repeat (3) @(posedge clk);
        #1;

        send(8'hFF, 4'h0, 1'b0, 11);
        check_frame("ff_break");
        repeat (40) @(posedge clk);
        #1;
        check_idle("break_held");
        r_x = 4'hF;
        repeat (5) @(posedge clk);
        #1;
        check_idle("break_end");

        r_x = 4'h0;
        repeat (4) @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) chk($sformatf("glitch busy_hi[%0d]", m), 32'(busy[m]), 1);
        repeat (1) @(posedge clk);
        #1;
        r_x = 4'hF;
        repeat (HALF - 1) @(posedge clk);
        #1;
        check_idle("glitch");

        send(8'hC3, 4'h0, 1'b1, 5);
        r_x = 4'h0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset("abort");
        for (int m = 0; m < 4; m++) chk($sformatf("abort pulses[%0d]", m), vcnt[m], exp_cnt[m]);
        r_x = 4'hF;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(8'h5A, 4'h0, 1'b1, 11);
        check_frame("5a_after_rst");

        send(8'h01, 4'h0, 1'b1, 11);
        check_frame("b2b_01");
        send(8'h80, 4'h0, 1'b1, 11);
        check_frame("b2b_80");

        for (int i = 0; i < 8; i++) begin
            d    = 8'($urandom);
            flip = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            stop = $urandom_range(0, 3) != 0;
            send(d, flip, stop, 11);
            check_frame($sformatf("rnd%0d", i));
            r_x = 4'hF;
            repeat (stop ? $urandom_range(0, 10) : $urandom_range(2, 10)) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
